// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to imem,
// buffers in-order responses in a small queue and presents them to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus8,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [OW-1:0] r_out_cnt;
    logic [OW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_q_data [QDEPTH];
    logic [31:0]   r_q_pc   [QDEPTH];

    logic          w_rsp_live;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_accept;
    logic [31:0]   w_credit_used;
    logic [31:0]   w_redirect_pc;
    logic [OW-1:0] w_out_next;
    logic          w_unused_pc_lsb;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp_live    = imem_rsp_valid && (r_out_cnt != '0);
    assign w_drop        = (r_drop_cnt != '0);
    assign w_push        = w_rsp_live && !w_drop && !redirect_valid;
    assign w_pop         = (r_count != '0) && instr_ready && !redirect_valid;
    assign w_accept      = imem_req_valid && imem_req_ready;
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_unused_pc_lsb = &{1'b0, redirect_pc[1:0]};

    // Queue slots already spoken for: held entries plus live (non-stale) requests.
    assign w_credit_used = 32'(r_count) + 32'(r_out_cnt) - 32'(r_drop_cnt);

    assign imem_req_valid = reset && !redirect_valid
                            && (32'(r_out_cnt) < 32'(MAX_OUT))
                            && (w_credit_used < 32'(QDEPTH));
    assign imem_addr      = r_fetch_pc;

    assign instr_valid = (r_count != '0);
    assign instr       = instr_valid ? r_q_data[r_rd_ptr] : 32'd0;
    assign instr_pc    = instr_valid ? r_q_pc[r_rd_ptr]   : 32'd0;
    assign pc_plus8    = instr_valid ? (r_q_pc[r_rd_ptr] + 32'd8) : 32'd0;

    always_comb begin
        w_out_next = r_out_cnt;
        if (w_accept) begin
            w_out_next = w_out_next + OW'(1);
        end
        if (w_rsp_live) begin
            w_out_next = w_out_next - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight belongs to the old stream.
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
            r_out_cnt  <= w_out_next;
            r_drop_cnt <= w_out_next;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_out_cnt <= w_out_next;
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_rsp_live && w_drop) begin
                r_drop_cnt <= r_drop_cnt - OW'(1);
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= imem_rsp_data;
            r_q_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order memory model with random latency,
// expected instruction stream tracked per redirect epoch.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] XMASK    = 32'hE000_0000;

    logic        clk            = 1'b0;
    logic        reset          = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'd0;
    logic        instr_valid;
    logic        instr_ready    = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus8;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'd0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH),
        .MAX_OUT  (MAX_OUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_plus8       (pc_plus8),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; } exp_t;

    req_t        mem_q[$];
    exp_t        exp_q[$];
    int          n_cmp     = 0;
    int          n_bad     = 0;
    int          epoch     = 0;
    int          cycle     = 0;
    int          last_due  = 0;
    int          cur_lat   = 1;
    logic [31:0] exp_fetch = RESET_PC;
    logic        exp_req_v = 1'b0;
    logic        s_valid   = 1'b0;
    logic [31:0] s_addr    = 32'd0;
    bit          done      = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cycle);
        end
    endtask

    // Monitor: DUT queue must mirror the expected stream; pops are compared in order.
    always @(negedge clk) begin
        exp_t e;
        if (!done) begin
            check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_q.size() != 0});
            if (instr_valid && instr_ready && !redirect_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("instr", instr, e.data);
                check("instr_pc", instr_pc, e.pc);
                check("pc_plus8", pc_plus8, e.pc + 32'd8);
            end
        end
    end

    task automatic drive(input int m);
        redirect_valid = 1'b0;
        case (m)
            0: begin imem_req_ready = 1'b1; instr_ready = 1'b1; cur_lat = 1; end
            1: begin imem_req_ready = 1'b1; instr_ready = 1'b0; cur_lat = 1; end
            2: begin
                imem_req_ready = ($urandom_range(3) != 0);
                instr_ready    = ($urandom_range(2) != 0);
                cur_lat        = $urandom_range(3, 1);
                redirect_valid = ($urandom_range(11) == 0);
                redirect_pc    = $urandom;
            end
            3: begin imem_req_ready = 1'b0; instr_ready = 1'b1; end
            4: begin imem_req_ready = 1'b1; instr_ready = 1'b1; cur_lat = 3; end
            5: begin
                imem_req_ready = 1'b1; instr_ready = 1'b1; cur_lat = 3;
                redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
            end
            default: begin imem_req_ready = 1'b0; instr_ready = 1'b1; end
        endcase
        imem_rsp_valid = (mem_q.size() != 0) && (mem_q[0].due <= cycle);
        imem_rsp_data  = imem_rsp_valid ? (mem_q[0].addr ^ XMASK) : $urandom;
    endtask

    // One clock: settle the finished cycle into the model, drive, then check requests.
    task automatic step(input int m);
        req_t r;
        int   due;
        int   stale;
        @(posedge clk);
        if (imem_rsp_valid) begin
            r = mem_q.pop_front();
            if (!redirect_valid && r.epoch == epoch) begin
                exp_q.push_back('{r.addr ^ XMASK, r.addr});
            end
        end
        if (redirect_valid) begin
            exp_q.delete();
            epoch++;
            exp_fetch = {redirect_pc[31:2], 2'b00};
        end else if (s_valid && imem_req_ready) begin
            due = cycle + cur_lat;
            if (due <= last_due) due = last_due + 1;
            mem_q.push_back('{s_addr, epoch, due});
            last_due  = due;
            exp_fetch = exp_fetch + 32'd4;
        end
        cycle++;
        #1;
        drive(m);
        stale = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
        exp_req_v = !redirect_valid && (mem_q.size() < MAX_OUT)
                    && (exp_q.size() + mem_q.size() - stale < QDEPTH);
        @(negedge clk);
        s_valid = imem_req_valid;
        s_addr  = imem_addr;
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req_v});
        if (imem_req_valid) check("req_addr", imem_addr, exp_fetch);
    endtask

    task automatic run(input int m, input int n);
        for (int i = 0; i < n; i++) step(m);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
        check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        check({tag, "_instr"}, instr, 32'd0);
        check({tag, "_instr_pc"}, instr_pc, 32'd0);
        check({tag, "_pc_plus8"}, pc_plus8, 32'd0);
    endtask

    task automatic mid_reset();
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        mem_q.delete();
        exp_q.delete();
        exp_fetch      = RESET_PC;
        last_due       = 0;
        s_valid        = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(posedge clk);
        #1 reset = 1'b1;

        run(0, 30);   // streaming from RESET_PC
        run(1, 10);   // decoder stalled: queue fills, requests stop
        run(0, 15);
        run(3, 5);    // memory stalled: request held with stable address
        run(0, 10);
        run(4, 8);    // long latency, two in flight
        run(5, 1);    // redirect to 0x103 with stale responses pending
        run(4, 20);
        run(2, 400);
        run(1, 6);
        mid_reset();
        run(0, 20);
        run(2, 400);
        run(6, 15);   // drain

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
